// File: rtl/fp_mul_pkg.sv
// ============================================================
// Module   : fp_mul_pkg
// Brief    : Shared widths, field offsets, bias/saturation helpers and
//            the S2 stage record for the fp_mul_pipe multiplier.
// Revision : 1.0
// ============================================================
`default_nettype none

package fp_mul_pkg;

    localparam int EXP_W_DEF  = 7;
    localparam int FRAC_W_DEF = 16;
    localparam int W_DEF      = 1 + EXP_W_DEF + FRAC_W_DEF;
    localparam int FP_PROD_W  = 2 * FRAC_W_DEF + 2;
    localparam int FP_ESUM_W  = EXP_W_DEF + 2;

    localparam int SIGN_POS = W_DEF - 1;
    localparam int EXP_LSB  = FRAC_W_DEF;
    localparam int FRAC_LSB = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Largest representable magnitude: exponent all-ones is an ordinary normal.
    function automatic logic [W_DEF-1:0] fp_sat_word(input logic sign);
        return {sign, {(W_DEF-1){1'b1}}};
    endfunction

    typedef struct packed {
        logic                        valid;
        logic                        sign;
        logic signed [FP_ESUM_W-1:0] e_sum;
        logic [FP_PROD_W-1:0]        prod;
        logic                        zero;
    } fp_stage_t;

endpackage

`default_nettype wire

// File: rtl/fp_norm_round.sv
// ============================================================
// Module   : fp_norm_round
// Brief    : Combinational normalise, optional RNE rounding (FP_MUL_ROUND_EN),
//            zero/overflow/underflow resolution of one S2 product.
// Revision : 1.0
// ============================================================
`default_nettype none

module fp_norm_round
    import fp_mul_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int W      = 1 + EXP_W + FRAC_W
) (
    input  fp_stage_t      stage_i,
    output logic [W-1:0]   data_o,
    output logic           ovf_o,
    output logic           unf_o
);

    localparam int PW = 2 * FRAC_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_MIN = EW'(1);

    logic [FRAC_W-1:0]    frac_n;
    logic [FRAC_W-1:0]    frac_r;
    logic signed [EW-1:0] e_n;
    logic signed [EW-1:0] e_r;
    logic                 guard;
    logic                 sticky;
    logic                 unused_bits;

    // Product of two [1,2) significands lies in [1,4): at most one shift.
    always_comb begin
        if (stage_i.prod[PW-1]) begin
            frac_n = stage_i.prod[PW-2 -: FRAC_W];
            guard  = stage_i.prod[PW-2-FRAC_W];
            sticky = |stage_i.prod[PW-3-FRAC_W:0];
            e_n    = stage_i.e_sum + EW'(1);
        end else begin
            frac_n = stage_i.prod[PW-3 -: FRAC_W];
            guard  = stage_i.prod[PW-3-FRAC_W];
            sticky = |stage_i.prod[PW-4-FRAC_W:0];
            e_n    = stage_i.e_sum;
        end
    end

`ifdef FP_MUL_ROUND_EN
    logic            round_up;
    logic [FRAC_W:0] frac_sum;

    always_comb begin
        round_up = guard & (sticky | frac_n[0]);
        frac_sum = {1'b0, frac_n} + {{FRAC_W{1'b0}}, round_up};
        frac_r   = frac_sum[FRAC_W-1:0];
        e_r      = frac_sum[FRAC_W] ? e_n + EW'(1) : e_n;
    end
`else
    always_comb begin
        frac_r = frac_n;
        e_r    = e_n;
    end
`endif

    assign unused_bits = ^{stage_i.valid, guard, sticky};

    always_comb begin
        data_o = {stage_i.sign, e_r[EXP_W-1:0], frac_r};
        ovf_o  = 1'b0;
        unf_o  = 1'b0;
        if (stage_i.zero) begin
            data_o = {stage_i.sign, {(W-1){1'b0}}};
        end else if (e_r > E_MAX) begin
            data_o = fp_sat_word(stage_i.sign);
            ovf_o  = 1'b1;
        end else if (e_r < E_MIN) begin
            data_o = {stage_i.sign, {(W-1){1'b0}}};
            unf_o  = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_mul_pipe.sv
// ============================================================
// Module   : fp_mul_pipe
// Brief    : 3-stage elastic floating-point multiplier with saturation and
//            zero flush; define FP_MUL_ROUND_EN for round-to-nearest-even.
// Revision : 1.0
// ============================================================
`default_nettype none

module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int W      = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    output logic         out_unf
);

    localparam logic [FP_ESUM_W-1:0] BIAS = FP_ESUM_W'(fp_bias(EXP_W));

    logic         en;
    logic         s1_valid_q;
    logic [W-1:0] s1_a_q;
    logic [W-1:0] s1_b_q;
    fp_stage_t    s2_d;
    fp_stage_t    s2_q;
    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic         out_ovf_q;
    logic         out_unf_q;

    logic [EXP_W-1:0]  ea;
    logic [EXP_W-1:0]  eb;
    logic [FRAC_W-1:0] fa;
    logic [FRAC_W-1:0] fb;
    logic [W-1:0]      norm_data;
    logic              norm_ovf;
    logic              norm_unf;

    // One stall signal for the whole pipe: the output slot decides everything.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    assign ea = s1_a_q[EXP_LSB +: EXP_W];
    assign eb = s1_b_q[EXP_LSB +: EXP_W];
    assign fa = s1_a_q[FRAC_LSB +: FRAC_W];
    assign fb = s1_b_q[FRAC_LSB +: FRAC_W];

    always_comb begin
        s2_d       = '0;
        s2_d.valid = s1_valid_q;
        s2_d.sign  = s1_a_q[SIGN_POS] ^ s1_b_q[SIGN_POS];
        s2_d.e_sum = {2'b00, ea} + {2'b00, eb} - BIAS;
        s2_d.prod  = FP_PROD_W'({1'b1, fa}) * FP_PROD_W'({1'b1, fb});
        s2_d.zero  = (ea == '0) || (eb == '0);
    end

    fp_norm_round #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W),
        .W      (W)
    ) u_norm_round (
        .stage_i (s2_q),
        .data_o  (norm_data),
        .ovf_o   (norm_ovf),
        .unf_o   (norm_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            s1_a_q      <= in_a;
            s1_b_q      <= in_b;
            s2_q        <= s2_d;
            out_valid_q <= s2_q.valid;
            out_data_q  <= norm_data;
            out_ovf_q   <= norm_ovf;
            out_unf_q   <= norm_unf;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
// ============================================================
// Module   : tb_fp_mul_pipe
// Brief    : Directed-vector bench for fp_mul_pipe (follows FP_MUL_ROUND_EN).
// Revision : 1.0
// ============================================================
`default_nettype none

module tb_fp_mul_pipe;

    localparam int W  = 24;
    localparam int NV = 18;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         out_unf;

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y_trn;
        logic [W-1:0] y_rnd;
        logic         ovf;
        logic         unf;
    } vec_t;

    vec_t vecs [NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] exp_y(input vec_t v);
`ifdef FP_MUL_ROUND_EN
        return v.y_rnd;
`else
        return v.y_trn;
`endif
    endfunction

    task automatic run_vec(input string name, input vec_t v);
        int cyc;
        @(negedge clk);
        in_a      = v.a;
        in_b      = v.b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'd3);
        check({name, " data"}, 32'(out_data), 32'(exp_y(v)));
        check({name, " ovf"}, 32'(out_ovf), 32'(v.ovf));
        check({name, " unf"}, 32'(out_unf), 32'(v.unf));
    endtask

    task automatic stream_test();
        int           sent = 0;
        int           recv = 0;
        int           c = 0;
        int           extra = 0;
        logic         stalled = 1'b0;
        logic [W+1:0] held = '0;
        while (recv < 8 && c < 60) begin
            @(negedge clk);
            in_valid = (sent < 8);
            if (sent < 8) begin
                in_a = vecs[sent].a;
                in_b = vecs[sent].b;
            end
            out_ready = !(c >= 4 && c <= 9);
            #1;
            if (stalled) begin
                check("bp hold valid", 32'(out_valid), 32'd1);
                check("bp hold data", 32'({out_ovf, out_unf, out_data}), 32'(held));
            end
            if (out_valid && !out_ready)
                check("bp in_ready low", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                check($sformatf("bp result %0d", recv), 32'(out_data), 32'(exp_y(vecs[recv])));
                check($sformatf("bp flags %0d", recv), 32'({out_ovf, out_unf}),
                      32'({vecs[recv].ovf, vecs[recv].unf}));
                recv++;
            end
            stalled = out_valid && !out_ready;
            held    = {out_ovf, out_unf, out_data};
            if (in_valid && in_ready)
                sent++;
            c++;
        end
        check("bp recv count", 32'(recv), 32'd8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("bp no extra", 32'(extra), 32'd0);
    endtask

    task automatic reset_mid_stream();
        int stale = 0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_a = vecs[1].a; in_b = vecs[1].b;
        @(negedge clk);
        in_a = vecs[2].a; in_b = vecs[2].b;
        @(negedge clk);
        in_a = vecs[6].a; in_b = vecs[6].b;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst mid out_valid", 32'(out_valid), 32'd0);
        check("rst mid in_ready", 32'(in_ready), 32'd1);
        check("rst mid out_data", 32'(out_data), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst mid no stale", 32'(stale), 32'd0);
        run_vec("post-reset", vecs[15]);
    endtask

    initial begin
        //           a            b            trunc        round        ovf   unf
        vecs[0]  = '{24'h3F0000, 24'hC00000, 24'hC00000, 24'hC00000, 1'b0, 1'b0};
        vecs[1]  = '{24'h3F8000, 24'h3F8000, 24'h402000, 24'h402000, 1'b0, 1'b0};
        vecs[2]  = '{24'h7F0000, 24'h7F0000, 24'h7FFFFF, 24'h7FFFFF, 1'b1, 1'b0};
        vecs[3]  = '{24'h010000, 24'h010000, 24'h000000, 24'h000000, 1'b0, 1'b1};
        vecs[4]  = '{24'h000000, 24'hC00000, 24'h800000, 24'h800000, 1'b0, 1'b0};
        vecs[5]  = '{24'h3F0001, 24'h3F8000, 24'h3F8001, 24'h3F8002, 1'b0, 1'b0};
        vecs[6]  = '{24'h400000, 24'h408000, 24'h418000, 24'h418000, 1'b0, 1'b0};
        vecs[7]  = '{24'hBF8000, 24'hC00000, 24'h408000, 24'h408000, 1'b0, 1'b0};
        vecs[8]  = '{24'h7F0000, 24'h3F0000, 24'h7F0000, 24'h7F0000, 1'b0, 1'b0};
        vecs[9]  = '{24'h7F8000, 24'h3F8000, 24'h7FFFFF, 24'h7FFFFF, 1'b1, 1'b0};
        vecs[10] = '{24'h200000, 24'h200000, 24'h010000, 24'h010000, 1'b0, 1'b0};
        vecs[11] = '{24'h1F0000, 24'h200000, 24'h000000, 24'h000000, 1'b0, 1'b1};
        vecs[12] = '{24'h1F8000, 24'h208000, 24'h012000, 24'h012000, 1'b0, 1'b0};
        vecs[13] = '{24'h9F0000, 24'h200000, 24'h800000, 24'h800000, 1'b0, 1'b1};
        vecs[14] = '{24'h3F0003, 24'h3F8000, 24'h3F8004, 24'h3F8004, 1'b0, 1'b0};
        vecs[15] = '{24'h3F0001, 24'h3FC000, 24'h3FC001, 24'h3FC002, 1'b0, 1'b0};
        vecs[16] = '{24'h000000, 24'h010000, 24'h000000, 24'h000000, 1'b0, 1'b0};
        vecs[17] = '{24'h800000, 24'h3F0000, 24'h800000, 24'h800000, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset flags", 32'({out_ovf, out_unf}), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        stream_test();
        reset_mid_stream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
